alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Execute-side issue stage that sits directly upstream of the ALU.
- Accepts decoded ALU micro-ops from decode, buffers them in a small in-order FIFO, and patches stale rs/rt values from two writeback bypass ports, including while an entry waits.
- Presents fully resolved x/y/op operands to the ALU with a valid/ready handshake.
- Absorbs downstream stalls without combinational ready paths back to decode.

Parameters:
DEPTH, 2, number of buffered entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries (branch mispredict/exception)
in_valid  in  1  decode presents a micro-op
in_ready  out  1  stage can accept; registered, equals !full
in_pc  in  32  instruction PC
in_rs_idx  in  5  rs register number
in_rt_idx  in  5  rt register number
in_rs_val  in  32  rs value read at decode
in_rt_val  in  32  rt value read at decode
in_imm  in  32  immediate, already sign/zero-extended by decode
in_shamt  in  5  shift amount field
in_xsel  in  2  x source: 0 rs, 1 {27'b0,shamt}, 2 pc, 3 reserved (x=0)
in_ysel  in  1  y source: 0 rt, 1 imm
in_op  in  4  ALU opcode (ALU_* encodings from defs.sv)
in_rd  in  5  destination register
in_wen  in  1  destination write enable
fwd0_wen, fwd0_idx, fwd0_data  in  1/5/32  bypass port 0 (younger producer, higher priority)
fwd1_wen, fwd1_idx, fwd1_data  in  1/5/32  bypass port 1 (older producer)
out_valid  out  1  head entry valid
out_ready  in  1  ALU/EX consumer accepts head
out_x, out_y  out  32  resolved ALU operands
out_op  out  4  ALU opcode
out_rd  out  5  destination register
out_wen  out  1  destination write enable
out_pc  out  32  PC of head entry

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries holding pc, rs/rt idx+val, imm, shamt, xsel, ysel, op, rd, wen.
  - Head/tail pointers wrap modulo DEPTH; occupancy counter runs 0..DEPTH.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH), computed from registered state only. No push while full, even if a pop occurs the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Latency: an entry pushed at edge N is visible on out_* from cycle N+1; min latency 1 cycle; strict FIFO order.
- out_valid = (count != 0). The out_* fields come combinationally from the head entry:
  - out_x: rs_val, {27'b0,shamt}, pc, or 0, according to xsel.
  - out_y: imm if ysel=1, else rt_val.
  - When out_valid=0, out_* are don't-care; the bench checks them only when valid.
- Forwarding:
  - At push, in_rs_val is replaced by fwd data when fwd_wen && fwd_idx == in_rs_idx && idx != 0. fwd0 wins over fwd1. in_rt_val is treated the same way.
  - Each cycle, every valid stored entry whose rs_idx/rt_idx matches an active bypass (idx != 0) has its stored value overwritten, with the same priority.
  - An entry popping in the same cycle is not updated.
  - Register 0 is never forwarded.
- Flush:
  - Synchronous; count, head, and tail reset to 0.
  - Flush wins over a simultaneous push or pop: the pushed op is dropped, and the popped op still counts as consumed by the downstream stage.
- Reset: count=0, head=tail=0, in_ready=1, out_valid=0, and all stored entries cleared to 0 (so out_* read 0). Reset mid-operation discards all entries the same as flush.
- Widths: shamt is zero-extended to 32 bits; no other arithmetic on the datapath.

Test Plan:
1. Single op: push ADD (op=ALU_ADD, xsel=0, ysel=0, rs_val=5, rt_val=7) with out_ready=1 -> out_valid=1 next cycle with out_x=5, out_y=7; out_valid=0 after the pop; count returns to 0.
2. Backpressure: out_ready=0, push 3 ops -> in_ready falls to 0 after 2 pushes and the third is not accepted. Raise out_ready -> ops emerge in order (pc 0x100, 0x104), then in_ready=1.
3. Operand selection:
   - SLL with shamt=4, xsel=1, ysel=0, rt_val=0x1 -> out_x=0x4, out_y=0x1.
   - PC8 with xsel=2, pc=0x400 -> out_x=0x400.
   - ADDI with ysel=1, imm=0xFFFFFFF0 -> out_y=0xFFFFFFF0.
4. Forwarding at push and while held:
   - Push with rs_idx=3 while fwd1 writes r3=0xAA and fwd0 writes r3=0xBB -> out_x=0xBB.
   - Hold the entry (out_ready=0); fwd1 later writes r3=0xCC -> out_x=0xCC.
   - fwd0 writes r0=0x55 to an entry with rt_idx=0 -> out_y unchanged.
5. Flush: with 2 entries buffered, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the pushed op is lost.
6. Reset mid-stream: rst with 1 entry and in_valid=1 -> out_valid=0 and in_ready=1 after the edge; a subsequent push behaves exactly as in scenario 1.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// ----------------------------------------------------------------------------
// alu_operand_stage_if
// Bundles the decode-side push bus, the two writeback bypass ports and the
// ALU-side pop bus of the ALU operand stage.
//   slave  : the operand stage itself (consumes micro-ops, produces operands)
//   master : the environment around it (decode, writeback, ALU)
// Signals:
//   in_*      decode micro-op, in_valid/in_ready handshake
//   fwd0_*    bypass port 0 (younger producer, wins on conflicts)
//   fwd1_*    bypass port 1 (older producer)
//   out_*     resolved operands, out_valid/out_ready handshake
// ----------------------------------------------------------------------------
interface alu_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs_idx;
    logic [4:0]  in_rt_idx;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] in_imm;
    logic [4:0]  in_shamt;
    logic [1:0]  in_xsel;
    logic        in_ysel;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic        in_wen;

    logic        fwd0_wen;
    logic [4:0]  fwd0_idx;
    logic [31:0] fwd0_data;
    logic        fwd1_wen;
    logic [4:0]  fwd1_idx;
    logic [31:0] fwd1_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [3:0]  out_op;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_pc;

    modport slave (
        input  in_valid, in_pc, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
               in_imm, in_shamt, in_xsel, in_ysel, in_op, in_rd, in_wen,
               fwd0_wen, fwd0_idx, fwd0_data, fwd1_wen, fwd1_idx, fwd1_data,
               out_ready,
        output in_ready, out_valid, out_x, out_y, out_op, out_rd, out_wen, out_pc
    );

    modport master (
        output in_valid, in_pc, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
               in_imm, in_shamt, in_xsel, in_ysel, in_op, in_rd, in_wen,
               fwd0_wen, fwd0_idx, fwd0_data, fwd1_wen, fwd1_idx, fwd1_data,
               out_ready,
        input  in_ready, out_valid, out_x, out_y, out_op, out_rd, out_wen, out_pc
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ----------------------------------------------------------------------------
// alu_operand_stage
// In-order issue buffer directly upstream of the ALU. Decoded micro-ops are
// queued in a DEPTH-entry circular buffer; stale rs/rt values are patched from
// two writeback bypass ports both at push time and while an entry waits. The
// head entry drives fully resolved x/y operands to the ALU.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset (clears all stored entries)
//   flush_i  synchronous discard of all buffered entries
//   bus      alu_operand_stage_if.slave (decode push, bypass, ALU pop)
// in_ready is a register (never combinational from out_ready).
// ----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    alu_operand_stage_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  xsel;
        logic        ysel;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           in_ready_q, in_ready_d;

    logic           push_s;
    logic           pop_s;
    entry_t         head_s;

    // Bypass select: register 0 is never forwarded, port 0 beats port 1.
    function automatic logic [31:0] fwd_val(
        input logic [4:0]  idx,
        input logic [31:0] val,
        input logic        f0_wen,
        input logic [4:0]  f0_idx,
        input logic [31:0] f0_data,
        input logic        f1_wen,
        input logic [4:0]  f1_idx,
        input logic [31:0] f1_data
    );
        if (idx == 5'd0) begin
            return val;
        end else if (f0_wen && (f0_idx == idx)) begin
            return f0_data;
        end else if (f1_wen && (f1_idx == idx)) begin
            return f1_data;
        end else begin
            return val;
        end
    endfunction

    // Slot idx holds a live entry when its distance from head is below count.
    function automatic logic slot_live(
        input logic [PW-1:0] idx,
        input logic [PW-1:0] head,
        input logic [CW-1:0] cnt
    );
        logic [PW-1:0] off;
        off = idx - head;
        return ({1'b0, off} < cnt);
    endfunction

    assign push_s = bus.in_valid && in_ready_q;
    assign pop_s  = (count_q != {CW{1'b0}}) && bus.out_ready;

    // Next-state: bypass patching of held entries, push, pointer/count update, flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        // Held entries pick up bypass data; the entry leaving this cycle is skipped.
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live(PW'(i), head_q, count_q) && !(pop_s && (PW'(i) == head_q))) begin
                mem_d[i].rs_val = fwd_val(mem_q[i].rs_idx, mem_q[i].rs_val,
                                          bus.fwd0_wen, bus.fwd0_idx, bus.fwd0_data,
                                          bus.fwd1_wen, bus.fwd1_idx, bus.fwd1_data);
                mem_d[i].rt_val = fwd_val(mem_q[i].rt_idx, mem_q[i].rt_val,
                                          bus.fwd0_wen, bus.fwd0_idx, bus.fwd0_data,
                                          bus.fwd1_wen, bus.fwd1_idx, bus.fwd1_data);
            end else begin
                mem_d[i] = mem_q[i];
            end
        end

        if (push_s) begin
            mem_d[tail_q].pc     = bus.in_pc;
            mem_d[tail_q].rs_idx = bus.in_rs_idx;
            mem_d[tail_q].rt_idx = bus.in_rt_idx;
            mem_d[tail_q].rs_val = fwd_val(bus.in_rs_idx, bus.in_rs_val,
                                           bus.fwd0_wen, bus.fwd0_idx, bus.fwd0_data,
                                           bus.fwd1_wen, bus.fwd1_idx, bus.fwd1_data);
            mem_d[tail_q].rt_val = fwd_val(bus.in_rt_idx, bus.in_rt_val,
                                           bus.fwd0_wen, bus.fwd0_idx, bus.fwd0_data,
                                           bus.fwd1_wen, bus.fwd1_idx, bus.fwd1_data);
            mem_d[tail_q].imm    = bus.in_imm;
            mem_d[tail_q].shamt  = bus.in_shamt;
            mem_d[tail_q].xsel   = bus.in_xsel;
            mem_d[tail_q].ysel   = bus.in_ysel;
            mem_d[tail_q].op     = bus.in_op;
            mem_d[tail_q].rd     = bus.in_rd;
            mem_d[tail_q].wen    = bus.in_wen;
            tail_d               = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush overrides any push/pop; the popped op still left downstream.
        if (flush_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_d;
        end

        in_ready_d = (count_d != FULL_CNT);
    end

    // State registers with synchronous reset clearing storage and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            in_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign head_s = mem_q[head_q];

    // Operand muxing from the head entry; reserved xsel reads as zero.
    always_comb begin
        case (head_s.xsel)
            2'd0:    bus.out_x = head_s.rs_val;
            2'd1:    bus.out_x = {27'd0, head_s.shamt};
            2'd2:    bus.out_x = head_s.pc;
            default: bus.out_x = 32'd0;
        endcase
        if (head_s.ysel) begin
            bus.out_y = head_s.imm;
        end else begin
            bus.out_y = head_s.rt_val;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != {CW{1'b0}});
    assign bus.out_op    = head_s.op;
    assign bus.out_rd    = head_s.rd;
    assign bus.out_wen   = head_s.wen;
    assign bus.out_pc    = head_s.pc;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed bench for alu_operand_stage: a table of single-op vectors with
// hand-computed operands, followed by hand-written sequences for
// backpressure, forwarding, flush and mid-stream reset.
// ----------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_PC8 = 4'd10;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  xsel;
        logic        ysel;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp_x;
        logic [31:0] exp_y;
    } vec_t;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   failures;
    vec_t vecs [5];

    alu_operand_stage_if bus ();

    alu_operand_stage #(.DEPTH(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] pc, input logic [1:0] xsel, input logic ysel,
        input logic [3:0] op, input logic [31:0] rs_val, input logic [31:0] rt_val,
        input logic [31:0] imm, input logic [4:0] shamt,
        input logic [31:0] exp_x, input logic [31:0] exp_y
    );
        vec_t v;
        v.pc = pc; v.rs_idx = 5'd1; v.rt_idx = 5'd2;
        v.rs_val = rs_val; v.rt_val = rt_val; v.imm = imm; v.shamt = shamt;
        v.xsel = xsel; v.ysel = ysel; v.op = op; v.rd = 5'd9; v.wen = 1'b1;
        v.exp_x = exp_x; v.exp_y = exp_y;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.in_pc     = v.pc;
        bus.in_rs_idx = v.rs_idx;
        bus.in_rt_idx = v.rt_idx;
        bus.in_rs_val = v.rs_val;
        bus.in_rt_val = v.rt_val;
        bus.in_imm    = v.imm;
        bus.in_shamt  = v.shamt;
        bus.in_xsel   = v.xsel;
        bus.in_ysel   = v.ysel;
        bus.in_op     = v.op;
        bus.in_rd     = v.rd;
        bus.in_wen    = v.wen;
    endtask

    task automatic fwd_off();
        bus.fwd0_wen = 1'b0; bus.fwd0_idx = 5'd0; bus.fwd0_data = 32'd0;
        bus.fwd1_wen = 1'b0; bus.fwd1_idx = 5'd0; bus.fwd1_data = 32'd0;
    endtask

    task automatic push_pc(input logic [31:0] pc);
        vec_t v;
        v = mk(pc, 2'd0, 1'b0, ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd0, 32'd0, 32'd0);
        drive(v);
    endtask

    // Scenario-1 style single op: push, see it next cycle, see it leave.
    task automatic single_add(input string tag);
        vec_t v;
        v = mk(32'h0000_0010, 2'd0, 1'b0, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd0, 32'd5, 32'd7);
        bus.out_ready = 1'b1;
        drive(v);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_x"}, bus.out_x, 32'd5);
        chk({tag, "_y"}, bus.out_y, 32'd7);
        chk({tag, "_op"}, {28'd0, bus.out_op}, {28'd0, ALU_ADD});
        step();
        chk({tag, "_empty"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;

        vecs[0] = mk(32'h0000_0020, 2'd0, 1'b0, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd0,
                     32'd5, 32'd7);
        vecs[1] = mk(32'h0000_0024, 2'd1, 1'b0, ALU_SLL, 32'hDEAD_0000, 32'h1, 32'd0, 5'd4,
                     32'h4, 32'h1);
        vecs[2] = mk(32'h0000_0400, 2'd2, 1'b1, ALU_PC8, 32'h5555_5555, 32'h6666_6666, 32'd8,
                     5'd31, 32'h400, 32'd8);
        vecs[3] = mk(32'h0000_0028, 2'd0, 1'b1, ALU_ADD, 32'h10, 32'h99, 32'hFFFF_FFF0, 5'd0,
                     32'h10, 32'hFFFF_FFF0);
        vecs[4] = mk(32'h0000_002C, 2'd3, 1'b0, ALU_SUB, 32'h1234, 32'hABCD, 32'h1, 5'd7,
                     32'd0, 32'hABCD);

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        push_pc(32'd0);
        bus.in_valid = 1'b0;
        fwd_off();
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_x", bus.out_x, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);

        // Table of single ops: push with out_ready=1, check operands, then drain.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i]);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d_x", i), bus.out_x, vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), bus.out_y, vecs[i].exp_y);
            chk($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].pc);
            chk($sformatf("vec%0d_op", i), {28'd0, bus.out_op}, {28'd0, vecs[i].op});
            chk($sformatf("vec%0d_rd", i), {27'd0, bus.out_rd}, {27'd0, vecs[i].rd});
            step();
            chk($sformatf("vec%0d_drained", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure: third push refused while full, even when pop opens up.
        bus.out_ready = 1'b0;
        push_pc(32'h100);
        step();
        chk("bp_ready_after1", {31'd0, bus.in_ready}, 32'd1);
        push_pc(32'h104);
        step();
        chk("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
        push_pc(32'h108);
        step();
        chk("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_head0", bus.out_pc, 32'h100);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bp_head1", bus.out_pc, 32'h104);
        chk("bp_ready_again", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_valid1", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("bp_third_lost", {31'd0, bus.out_valid}, 32'd0);

        // Forwarding at push (fwd0 over fwd1) and while held.
        bus.out_ready = 1'b0;
        v = mk(32'h200, 2'd0, 1'b0, ALU_ADD, 32'h11, 32'h77, 32'd0, 5'd0, 32'd0, 32'd0);
        v.rs_idx = 5'd3;
        v.rt_idx = 5'd0;
        drive(v);
        bus.fwd1_wen = 1'b1; bus.fwd1_idx = 5'd3; bus.fwd1_data = 32'hAA;
        bus.fwd0_wen = 1'b1; bus.fwd0_idx = 5'd3; bus.fwd0_data = 32'hBB;
        step();
        bus.in_valid = 1'b0;
        fwd_off();
        chk("fwd_push_x", bus.out_x, 32'hBB);
        chk("fwd_push_y", bus.out_y, 32'h77);
        bus.fwd1_wen = 1'b1; bus.fwd1_idx = 5'd3; bus.fwd1_data = 32'hCC;
        step();
        fwd_off();
        chk("fwd_held_x", bus.out_x, 32'hCC);
        bus.fwd0_wen = 1'b1; bus.fwd0_idx = 5'd0; bus.fwd0_data = 32'h55;
        step();
        fwd_off();
        chk("fwd_r0_y", bus.out_y, 32'h77);
        bus.fwd0_wen = 1'b1; bus.fwd0_idx = 5'd3; bus.fwd0_data = 32'hDD;
        bus.fwd1_wen = 1'b1; bus.fwd1_idx = 5'd3; bus.fwd1_data = 32'hEE;
        step();
        fwd_off();
        chk("fwd_held_prio", bus.out_x, 32'hDD);
        bus.fwd1_wen = 1'b1; bus.fwd1_idx = 5'd4; bus.fwd1_data = 32'h44;
        step();
        fwd_off();
        chk("fwd_idx_miss", bus.out_x, 32'hDD);
        bus.out_ready = 1'b1;
        step();
        chk("fwd_drained", {31'd0, bus.out_valid}, 32'd0);

        // Flush with two buffered entries and a simultaneous push.
        bus.out_ready = 1'b0;
        push_pc(32'h300);
        step();
        push_pc(32'h304);
        step();
        push_pc(32'h308);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("flush_push_lost", {31'd0, bus.out_valid}, 32'd0);
        push_pc(32'h30C);
        step();
        bus.in_valid = 1'b0;
        chk("flush_after_pc", bus.out_pc, 32'h30C);
        bus.out_ready = 1'b1;
        step();
        chk("flush_after_drain", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-stream with one entry held and a push offered.
        bus.out_ready = 1'b0;
        push_pc(32'h500);
        step();
        push_pc(32'h504);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_mid_pc", bus.out_pc, 32'd0);
        single_add("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
